dram_burst_reader: RTL
======================

# dram_burst_reader

Read-side master for the dual-port `dram` block: given a base address and word count, it drives one dram port's address and streams the returned words out over a valid/ready interface. It absorbs the dram's one-cycle registered read latency and downstream backpressure with a 2-entry output buffer, sustaining one word per cycle when the consumer is always ready. It sits between a dram port (write port left idle) and any stream consumer, such as a trace exporter or host bridge.

## Interface

Parameters:
- `WORD_SIZE`, 64: dram word width.
- `ADDR_SIZE`, 8: dram address width; capacity 2**ADDR_SIZE words.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  burst request; sampled only in IDLE.
- `base_addr`  in  ADDR_SIZE  first word address, captured with `start`.
- `length`  in  ADDR_SIZE+1  word count, 0..2**ADDR_SIZE, captured with `start`.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `mem_address`  out  ADDR_SIZE  drives dram `address_N`.
- `mem_write_enable`  out  1  drives dram `write_enable_N`; constant 0.
- `mem_output`  in  WORD_SIZE  dram `output_N`; holds mem[address] sampled at the previous edge.
- `out_data`  out  WORD_SIZE  stream data (FIFO head).
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  consumer ready; transfer (pop) = `out_valid && out_ready` at an edge.
- `out_last`  out  1  high with the final word of the burst.

## Operation

- States: IDLE, READ, DRAIN.
- IDLE: `start`=1 at an edge -> capture `base_addr` into address counter, `length` into remaining count, `busy`<=1; if `length`=0 go to DRAIN, else READ.
- READ: a read *issues* at an edge when remaining>0 and (fifo_count + pending − pop) ≤ 1. On issue: pending<=1, address counter +1 (mod 2**ADDR_SIZE, wraps 0xFF->0x00), remaining −1, and the issued word's last flag = (remaining==1). Remaining reaching 0 -> DRAIN.
- pending: set at an issue edge, cleared otherwise; when pending=1 at an edge, `mem_output` plus its last flag are written into the FIFO.
- `mem_address` = address counter combinationally; the dram reads every cycle, and non-issue reads are discarded.
- FIFO: 2 entries, each holding data and last. Simultaneous push and pop are both performed and count is unchanged. Overflow cannot occur, by the issue rule. `out_valid` = count>0; `out_last` = head's last flag.
- DRAIN: when remaining=0, pending=0 and FIFO empty (including the edge that pops the last word) -> `done`<=1 for one cycle, `busy`<=0, IDLE.
- `start` while busy: ignored, with no effect on the captured parameters.
- Addresses wrap modulo 2**ADDR_SIZE; `length` = 2**ADDR_SIZE reads every word exactly once.
- `mem_write_enable` is 0 in every state, including during reset.

## Timing

- Reset (async assert, sync deassert by environment): state IDLE; `busy`, `done`, `out_valid`, `out_last`, `mem_write_enable` = 0; `mem_address`, `out_data` = 0; FIFO count, pending, remaining = 0.
- Reset mid-burst: FIFO contents and the in-flight read are dropped, with no `done`. After release, the block is idle and accepts a new `start`.
- Start accepted at edge E0: `mem_address`=base after E0. First read issues at E1. First `out_valid` after E2, so start-to-first-data latency is 2 cycles.
- With `out_ready` held at 1: one word per cycle; the N-word burst's last word is valid after edge E(N+1); `done` is high in the cycle after the last pop.
- Backpressure: `out_data`/`out_valid`/`out_last` hold stable while `out_valid && !out_ready`. At most 2 words are buffered, and issue resumes in the cycle after the first pop.
- `length`=0: `done` pulses in the cycle after E0 (after E1). `out_valid` never rises.

## Test plan

- Preload mem[0x10..0x13]=A0..A3, start base=0x10 len=4, ready=1 -> A0..A3 on consecutive cycles from 2 cycles after start; `out_last` only with A3; `done` one cycle after the A3 pop; `busy` then 0.
- Same burst with ready toggling 1,0,0,1,0,1… -> exactly A0..A3 in order, with no duplicates or drops; data stable while stalled; `out_valid` never high with a 3rd buffered word.
- base=0xFE len=4 -> words from addresses 0xFE, 0xFF, 0x00, 0x01 in order; last flag on the 0x01 word.
- len=0 -> `busy` for one cycle, `done` pulse, no `out_valid`. Then `start` pulsed mid-burst of a len=3 burst -> ignored, exactly 3 words out.
- Assert `rst_n`=0 after 2 words of a len=8 burst -> outputs at reset values immediately. After release, start base=0x20 len=2 -> exactly 2 correct words and one `done`.
- `mem_write_enable` observed 0 for the whole simulation; dram contents unchanged after all bursts.

Source files
------------

// File: rtl/dram_burst_reader_if.sv
// Output stream bundle of the dram burst reader: data/last with valid/ready handshake.
interface dram_burst_reader_if #(
    parameter int unsigned WORD_SIZE = 64
);
    logic [WORD_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/dram_burst_reader.sv
// Read-side master for one dram port: walks base..base+length-1 (wrapping) and
// streams the words through a 2-entry buffer that hides the read latency and backpressure.
module dram_burst_reader #(
    parameter int unsigned WORD_SIZE = 64,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] base_addr,
    input  logic [ADDR_SIZE:0]   length,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_SIZE-1:0] mem_address,
    output logic                 mem_write_enable,
    input  logic [WORD_SIZE-1:0] mem_output,
    dram_burst_reader_if.master  out_if
);
    localparam int unsigned CW = ADDR_SIZE + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

    typedef struct packed {
        logic                 last;
        logic [WORD_SIZE-1:0] data;
    } entry_t;

    state_e               state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [CW-1:0]        rem_q, rem_d;
    logic                 pend_q, pend_d;
    logic                 pend_last_q, pend_last_d;
    entry_t               head_q, head_d;
    entry_t               tail_q, tail_d;
    logic [1:0]           count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 pop;
    logic                 issue;
    entry_t               push_entry;

    // State register; reset drops buffered words and any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state: burst sequencing, read issue throttled so the buffer never exceeds 2 words.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        pend_d      = 1'b0;
        pend_last_d = pend_last_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        issue       = 1'b0;
        pop         = (count_q != 2'd0) && out_if.out_ready;
        push_entry.last = pend_last_q;
        push_entry.data = mem_output;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = length;
                    busy_d  = 1'b1;
                    state_d = (length == '0) ? DRAIN : READ;
                end
            end
            READ: begin
                // Count a word already in flight; a same-edge pop frees a slot.
                issue = (rem_q != '0) &&
                        ((3'(count_q) + 3'(pend_q)) <= (3'(pop) + 3'd1));
                if (issue) begin
                    pend_d      = 1'b1;
                    pend_last_d = (rem_q == CW'(1));
                    addr_d      = addr_q + ADDR_SIZE'(1);
                    rem_d       = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!pend_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Buffer update: head is always the oldest word; tail is cleared when not occupied.
        unique case ({pend_q, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = push_entry;
                end else begin
                    tail_d = push_entry;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                tail_d  = '0;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = push_entry;
                end else begin
                    head_d = tail_q;
                    tail_d = push_entry;
                end
            end
            default: ;
        endcase
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign mem_address      = addr_q;
    assign mem_write_enable = 1'b0;
    assign out_if.out_data  = head_q.data;
    assign out_if.out_last  = head_q.last;
    assign out_if.out_valid = (count_q != 2'd0);
endmodule
